uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver; the receive counterpart of the team's uart_tx on the same serial link.
//  Synchronises the asynchronous serial line and finds the start bit.
//  Samples each bit at mid-period, LSB first, and presents the byte with a one-cycle valid strobe.
//  Sits between the board-level RX pin and the byte-wide consumer logic.
// PARAMETERS
//  CLKS_PER_BIT  521  rx_clk cycles per bit (rx_clk freq / baud); 10 MHz / 19200 baud; must be >= 4
//  CNT_W  $clog2(CLKS_PER_BIT)+1  bit-period counter width; derived, do not override
// PORTS
//  rx_clk    in   1  receive clock; all logic is rising-edge
//  rx_rst_n  in   1  asynchronous active-low reset
//  rx_in     in   1  serial line, idle high, asynchronous to rx_clk
//  rx_out    out  8  last correctly framed byte; held until the next good frame
//  rx_dv     out  1  one-cycle pulse: rx_out has just been updated
//  rx_ferr   out  1  one-cycle pulse: stop bit sampled low (framing error)
//  rx_perr   out  1  one-cycle pulse: parity mismatch; constant 0 unless UART_RX_PARITY_EN
//  rx_busy   out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=IDLE, counters=0, shift reg=0.
//    - rx_out=8'h00; rx_dv=rx_ferr=rx_perr=rx_busy=0.
//    - Synchroniser flops reset to 1 (idle line).
//  - rx_in passes through a 2-flop synchroniser; the FSM uses only the second flop (rx_s).
//  - FSM states and transitions:
//    - IDLE:
//      - cnt=0, bit index=0.
//      - rx_s==0 -> START.
//    - START:
//      - Count to (CLKS_PER_BIT-1)/2 (integer division); then re-sample rx_s.
//      - rx_s==0 -> DATA with cnt=0 (cnt now aligned to bit centre).
//      - rx_s==1 -> IDLE (glitch/false start). No flag is raised.
//    - DATA:
//      - Count CLKS_PER_BIT-1, then shift rx_s into shift_reg[bit index], LSB first, and set cnt=0.
//      - After bit 7 -> PARITY if UART_RX_PARITY_EN, else STOP.
//    - PARITY (macro only):
//      - Count CLKS_PER_BIT-1, then sample and latch parity_ok.
//      - -> STOP.
//    - STOP:
//      - Count CLKS_PER_BIT-1, then sample rx_s.
//      - rx_s==1 -> rx_out<=shift_reg and rx_dv=1 for one cycle. With the macro, rx_perr=1 (and rx_dv=0) on mismatch.
//      - rx_s==0 -> rx_ferr=1 for one cycle; rx_out is unchanged; rx_dv=0.
//      - Always -> IDLE on the same edge.
//  - Return to IDLE happens at mid stop bit, so back-to-back frames are received with no lost start edge.
//  - After a framing error with rx_s still low, the FSM re-enters START from IDLE next cycle (break = repeated rx_ferr).
//  - Latency: rx_dv rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + ~3 cycles after the rx_in falling edge (+CLKS_PER_BIT with parity).
//  - rx_dv, rx_ferr and rx_perr are mutually exclusive; each lasts exactly 1 cycle.
//  - cnt never exceeds CLKS_PER_BIT-1; no wrap.
//  - Reset mid-frame aborts immediately. The partial byte is discarded and no flag pulses.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Frame is 8E1: an even-parity bit follows bit 7.
//    - Parity is good when ^{data,parity}==0.
//    - Bad parity with a good stop bit -> rx_perr pulse; rx_out is NOT updated.
//  UART_RX_PARITY_EN undefined:
//    - 8N1; PARITY state does not exist; rx_perr tied 1'b0.
// TESTING  (bench CLKS_PER_BIT=16)
//  1 Drive 8'hA5 8N1 at 16 clk/bit -> single rx_dv pulse, rx_out=8'hA5, rx_ferr=0, rx_busy low after.
//  2 Send 8'h00 then 8'hFF with zero idle gap -> two rx_dv pulses, 8'h00 then 8'hFF.
//  3 rx_in low for 4 clks then high -> FSM back to IDLE, no rx_dv/rx_ferr, rx_out unchanged.
//  4 Send 8'h3C with stop bit low -> rx_ferr pulse, no rx_dv, rx_out keeps previous 8'hFF.
//  5 Assert rx_rst_n=0 during bit 4 of 8'h5A -> all outputs 0 immediately; the next full 8'h81 frame is received correctly.
//  6 (UART_RX_PARITY_EN) 8'h07 with parity=1 -> rx_dv, 8'h07; with parity=0 -> rx_perr, no rx_dv.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with mid-bit sampling
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit follows data bit 7.
//   A parity mismatch raises rx_perr and leaves rx_out unchanged.
//
// Ports:
//   rx_clk    in   1  receive clock, all logic on rising edge
//   rx_rst_n  in   1  asynchronous active-low reset
//   rx_in     in   1  serial line, idle high, asynchronous to rx_clk
//   rx_out    out  8  last correctly framed byte, held until the next good frame
//   rx_dv     out  1  one-cycle pulse when rx_out has just been updated
//   rx_ferr   out  1  one-cycle pulse when the stop bit was sampled low
//   rx_perr   out  1  one-cycle pulse on parity mismatch (0 without UART_RX_PARITY_EN)
//   rx_busy   out  1  high whenever the receiver is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 521,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic       rx_clk,
    input  logic       rx_rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_out,
    output logic       rx_dv,
    output logic       rx_ferr,
    output logic       rx_perr,
    output logic       rx_busy
);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_out_q, rx_out_d;
    logic             dv_q, dv_d;
    logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic             perr_q, perr_d;
    logic             parity_ok_q, parity_ok_d;
`endif

    logic rx_s;
    assign rx_s = sync2_q;

    // Synchroniser resets to 1 so a reset never looks like a start bit.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_out_q    <= '0;
            dv_q        <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
            parity_ok_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_out_q    <= rx_out_d;
            dv_q        <= dv_d;
            ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q      <= perr_d;
            parity_ok_q <= parity_ok_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_out_d    = rx_out_q;
        dv_d        = 1'b0;
        ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d      = 1'b0;
        parity_ok_d = parity_ok_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = S_START;
            end
            // Wait half a bit, then confirm the line is still low; after this
            // point every full-period count lands on a bit centre.
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    parity_ok_d = ~(^{shift_q, rx_s});
                    state_d     = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            // Leave at mid stop bit so the next start edge is never missed.
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (parity_ok_q) begin
                            rx_out_d = shift_q;
                            dv_d     = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
`else
                        rx_out_d = shift_q;
                        dv_d     = 1'b1;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_out  = rx_out_q;
    assign rx_dv   = dv_q;
    assign rx_ferr = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_perr = perr_q;
`else
    assign rx_perr = 1'b0;
`endif
    assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_out;
    logic       rx_dv;
    logic       rx_ferr;
    logic       rx_perr;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .rx_clk   (clk),
        .rx_rst_n (rst_n),
        .rx_in    (rx_in),
        .rx_out   (rx_out),
        .rx_dv    (rx_dv),
        .rx_ferr  (rx_ferr),
        .rx_perr  (rx_perr),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts strobes, captures bytes, checks width and exclusivity.
    int         dv_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    logic [7:0] dv_bytes[$];
    logic       dv_prev = 1'b0;
    logic       ferr_prev = 1'b0;
    logic       perr_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_dv === 1'b1 || rx_ferr === 1'b1 || rx_perr === 1'b1) begin
            checks++;
            if ((int'(rx_dv) + int'(rx_ferr) + int'(rx_perr)) != 1 ||
                (dv_prev && rx_dv) || (ferr_prev && rx_ferr) || (perr_prev && rx_perr)) begin
                errors++;
                $display("FAIL pulse_shape: dv=%b ferr=%b perr=%b prev=%b%b%b required single one-cycle pulse",
                         rx_dv, rx_ferr, rx_perr, dv_prev, ferr_prev, perr_prev);
            end
        end
        if (rx_dv === 1'b1) begin
            dv_cnt++;
            dv_bytes.push_back(rx_out);
        end
        if (rx_ferr === 1'b1) ferr_cnt++;
        if (rx_perr === 1'b1) perr_cnt++;
        dv_prev   = (rx_dv === 1'b1);
        ferr_prev = (rx_ferr === 1'b1);
        perr_prev = (rx_perr === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) rx_in = 1'b1;
`endif
        drive_bit(stop);
        rx_in = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         dv_inc;
        int         ferr_inc;
        logic [7:0] out;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int d0, f0, p0;
        d0 = dv_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(v.data, ^v.data, v.stop);
        tick(40);
        check({tag, "_dv"},   dv_cnt - d0,   v.dv_inc);
        check({tag, "_ferr"}, ferr_cnt - f0, v.ferr_inc);
        check({tag, "_perr"}, perr_cnt - p0, 0);
        check({tag, "_out"},  rx_out,        v.out);
        check({tag, "_busy"}, rx_busy,       1'b0);
    endtask

    vec_t vecs[5];

    initial begin
        int d0, f0, p0;
        logic [7:0] b;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{8'hC3, 1'b1, 1, 0, 8'hC3};
        vecs[4] = '{8'h80, 1'b1, 1, 0, 8'h80};

        rst_n = 1'b0;
        rx_in = 1'b1;
        tick(3);
        check("reset_out",  rx_out,  8'h00);
        check("reset_dv",   rx_dv,   1'b0);
        check("reset_ferr", rx_ferr, 1'b0);
        check("reset_perr", rx_perr, 1'b0);
        check("reset_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back frames with no idle gap.
        d0 = dv_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        tick(40);
        check("b2b_count", dv_cnt - d0, 2);
        if (dv_bytes.size() >= 2) begin
            check("b2b_first",  dv_bytes[dv_bytes.size()-2], 8'h00);
            check("b2b_second", dv_bytes[dv_bytes.size()-1], 8'hFF);
        end else begin
            check("b2b_bytes", dv_bytes.size(), 2);
        end
        check("b2b_out", rx_out, 8'hFF);

        // Short low glitch: start is rejected at the half-bit check.
        d0 = dv_cnt; f0 = ferr_cnt;
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(2);
        check("glitch_busy_hi", rx_busy, 1'b1);
        tick(20);
        check("glitch_busy_lo", rx_busy, 1'b0);
        check("glitch_dv",   dv_cnt - d0,   0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_out",  rx_out, 8'hFF);

        // Framing error keeps the previous byte.
        run_vec('{8'h3C, 1'b0, 0, 1, 8'hFF}, "ferr");

        // Reset during bit 4 of 8'h5A, then a clean 8'h81 frame.
        d0 = dv_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_in = b[4];
        tick(8);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out",  rx_out,  8'h00);
        check("rst_mid_dv",   rx_dv,   1'b0);
        check("rst_mid_ferr", rx_ferr, 1'b0);
        check("rst_mid_busy", rx_busy, 1'b0);
        rx_in = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        check("rst_mid_noflag", (dv_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        run_vec('{8'h81, 1'b1, 1, 0, 8'h81}, "post_rst");

`ifdef UART_RX_PARITY_EN
        d0 = dv_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        tick(40);
        check("par_good_dv",   dv_cnt - d0,   1);
        check("par_good_perr", perr_cnt - p0, 0);
        check("par_good_out",  rx_out, 8'h07);
        d0 = dv_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        tick(40);
        check("par_bad_dv",   dv_cnt - d0,   0);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_out",  rx_out, 8'h07);
`else
        check("perr_tied", perr_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
